// File: rtl/store_write_buffer.sv
// Posted store write buffer: queues CPU stores and drains them to memory over req/gnt with byte-lane steering.
// Define STORE_BUF_HAZARD_EN to add ld_addr/ld_stall load-hazard detection against pending stores.
module store_write_buffer #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [31:0]   st_addr,
    input  logic [31:0]   st_data,
    input  logic          st_dt,
    output logic          mem_req,
    input  logic          mem_gnt,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    output logic          empty,
    output logic [CW-1:0] count,
`ifdef STORE_BUF_HAZARD_EN
    input  logic [31:0]   ld_addr,
    output logic          ld_stall,
`endif
    output logic          misalign_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, REQ} state_t;

    logic [31:0]   addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic          dt_mem   [DEPTH];

    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] rd_ptr_inc;
    logic [CW-1:0] count_reg;
    state_t        state_reg;

    logic          push;
    logic          pop;
    logic          more;
    logic          load;
    logic [31:0]   head_addr;
    logic [31:0]   head_data;
    logic          head_dt;
    logic [1:0]    lane;
    logic [31:0]   steer_wdata;
    logic [3:0]    steer_be;

    assign st_ready   = (count_reg < CW'(DEPTH));
    assign push       = st_valid & st_ready;
    assign pop        = (state_reg == REQ) & mem_gnt;
    assign more       = (count_reg > CW'(1)) | push;
    assign load       = ((state_reg == IDLE) && (count_reg != '0)) || (pop && more);
    assign rd_ptr_inc = rd_ptr_reg + 1'b1;
    assign count      = count_reg;
    assign empty      = (count_reg == '0) & ~mem_req;

    // On a grant with a single entry left, the next head is the store arriving this cycle.
    always_comb begin
        head_addr = addr_mem[rd_ptr_reg];
        head_data = data_mem[rd_ptr_reg];
        head_dt   = dt_mem[rd_ptr_reg];
        if (state_reg == REQ) begin
            if (count_reg > CW'(1)) begin
                head_addr = addr_mem[rd_ptr_inc];
                head_data = data_mem[rd_ptr_inc];
                head_dt   = dt_mem[rd_ptr_inc];
            end else begin
                head_addr = st_addr;
                head_data = st_data;
                head_dt   = st_dt;
            end
        end
    end

    always_comb begin
        lane = head_addr[1:0];
        if (head_dt) begin
            steer_wdata = head_data;
            steer_be    = 4'b0000;
        end else begin
            steer_wdata = {24'h000000, head_data[7:0]} << {lane, 3'b000};
            steer_be    = 4'b0001 << lane;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_reg] <= st_addr;
            data_mem[wr_ptr_reg] <= st_data;
            dt_mem[wr_ptr_reg]   <= st_dt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            state_reg    <= IDLE;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_be       <= '0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= push & st_dt & (st_addr[1:0] != 2'b00);
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_inc;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (load) begin
                mem_addr  <= {head_addr[31:2], 2'b00};
                mem_wdata <= steer_wdata;
                mem_be    <= steer_be;
            end
            case (state_reg)
                IDLE: begin
                    if (count_reg != '0) begin
                        mem_req   <= 1'b1;
                        state_reg <= REQ;
                    end
                end
                REQ: begin
                    if (mem_gnt && !more) begin
                        mem_req   <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    mem_req   <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef STORE_BUF_HAZARD_EN
    logic [DEPTH-1:0] hit;
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
        logic [PW-1:0] offs;
        // An entry is live when its distance from the read pointer is below the count.
        assign offs    = PW'(gi) - rd_ptr_reg;
        assign hit[gi] = (CW'(offs) < count_reg) &&
                         ({addr_mem[gi][31:2], 2'b00} == (ld_addr & 32'hFFFF_FFFC));
    end
    assign ld_stall = |hit;
`endif

endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Posted write buffer between the CPU store stage and the data-memory write port.
- Accepts store requests (address, data, size) through a valid/ready handshake and queues them in a small FIFO.
- Drains the FIFO to memory through a req/gnt handshake, steering byte data onto the correct lane and generating the byte-enable code.
- Lets the pipeline continue while memory is busy; optionally flags loads that hit a pending store.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, 2..16.
- CW, 3, width of the count output; equals log2(DEPTH)+1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- st_valid  in  1  store request valid
- st_ready  out  1  buffer can accept a store
- st_addr  in  32  byte address of the store
- st_data  in  32  store data; byte stores use bits [7:0]
- st_dt  in  1  data type: 1 = word, 0 = byte
- mem_req  out  1  write request to memory
- mem_gnt  in  1  memory accepts the current request
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- mem_wdata  out  32  lane-steered write data
- mem_be  out  4  byte enable: 0001/0010/0100/1000 = byte lane 0..3; 0000 = full-word write
- empty  out  1  FIFO empty and no request outstanding
- count  out  CW  number of stored entries, including the head being presented
- misalign_err  out  1  one-cycle pulse when a word store with addr[1:0]!=0 is accepted

Behaviour:
- Reset (async, rst_n=0): FIFO pointers and count = 0; FSM = IDLE; mem_req=0; mem_addr=0; mem_wdata=0; mem_be=0; misalign_err=0; st_ready=1; empty=1. Reset mid-transfer discards all entries and drops mem_req immediately.
- Enqueue: occurs on an edge with st_valid & st_ready. st_ready = (count < DEPTH). It is registered-count based, so a full buffer does not accept a store in the same cycle as a pop.
- Each entry holds addr[31:0], data[31:0] and dt.
- Lane steering, applied when the head is loaded into the output registers:
  - dt=0, lane = addr[1:0]: wdata = data[7:0] shifted to byte lane 'lane', other bits 0; be = one-hot(lane).
  - dt=1: wdata = data unchanged; be = 4'b0000.
- Misaligned word store (dt=1, addr[1:0]!=0): the store is still accepted and written as an aligned word. misalign_err pulses on the cycle after acceptance.
- FSM states:
  - IDLE: mem_req=0. Goes to REQ when count>0, loading the head into the mem_* registers on the same edge.
  - REQ: mem_req=1; mem_addr, mem_wdata and mem_be stay stable until granted.
  - On an edge with mem_gnt=1: pop the head. If entries remain after the pop, load the next head and stay in REQ (back-to-back, one write per cycle). Otherwise return to IDLE with mem_req=0.
  - mem_gnt is ignored in IDLE.
- Latency: a store accepted into an empty buffer at edge N makes mem_req visible after edge N+1. A grant at edge M frees the slot, so st_ready reflects it after edge M.
- Simultaneous push and pop: count unchanged, and the FIFO ordering is preserved.
- Pointers wrap modulo DEPTH.
- count saturates structurally: a push is impossible at DEPTH, and a pop is impossible at 0.
- empty = (count==0) & ~mem_req.

Optional Feature:
- Macro: STORE_BUF_HAZARD_EN.
- When defined, two ports are added:
  - ld_addr  in  32  load address
  - ld_stall  out  1  combinational stall
- ld_stall=1 when any valid entry's word address (addr[31:2]) equals ld_addr[31:2]. The pipeline holds the load until the matching store drains.
- When not defined, neither port exists, and loads must wait for empty=1.

Test Plan:
- Byte store, st_addr=0x00000103, st_data=0x000000AB, st_dt=0, mem_gnt=1 -> one cycle with mem_req=1, mem_addr=0x00000100, mem_wdata=0xAB000000, mem_be=4'b1000; then empty=1.
- Word store, st_addr=0x00000010, st_data=0xDEADBEEF, st_dt=1 -> mem_wdata=0xDEADBEEF, mem_be=4'b0000; misalign_err stays 0. The same store at 0x00000012 -> mem_addr=0x00000010 and misalign_err pulses for one cycle.
- mem_gnt=0, push 4 stores -> count=4, st_ready=0, and a 5th st_valid is not accepted. Then mem_gnt=1 for 4 cycles -> 4 consecutive writes in push order, count falls to 0, and st_ready=1 again after the first grant.
- Memory granting on every cycle with a continuous push stream -> count stays at 1, with one write per cycle and no bubbles.
- Reset asserted while in REQ with 3 entries -> mem_req=0, count=0 and empty=1 asynchronously; after rst_n rises, no stale writes are issued.
- With STORE_BUF_HAZARD_EN: pending store at 0x00000104 and ld_addr=0x00000106 -> ld_stall=1; ld_addr=0x00000108 -> ld_stall=0; after the store is granted -> ld_stall=0.
